// File: rtl/lc3_mem_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
//   Shared definitions for the LC-3 MAR/MDR memory controller: FSM state
//   encoding and the r_w direction constants.
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAM_WAIT = 2'd1,
    ST_IO_REQ   = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic R_W_WRITE = 1'b1;
  localparam logic R_W_READ  = 1'b0;

endpackage

// File: rtl/lc3_ram_array.sv
// ---------------------------------------------------------------------------
// lc3_ram_array
//   Single-port word RAM, synchronous write and synchronous read.
//   Ports:
//     clk    in   clock, rising edge
//     en     in   port enable (read when we=0, write when we=1)
//     we     in   write enable
//     addr   in   RAM_AW-bit word index
//     wdata  in   DW-bit write data
//     rdata  out  DW-bit read data, registered (valid the cycle after a read)
//   Contents are not reset.
// ---------------------------------------------------------------------------
module lc3_ram_array #(
  parameter int DW     = 16,
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [2**RAM_AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_mem_ctrl
//   MAR/MDR memory controller for the LC-3 datapath. Addresses below IO_BASE
//   go to an internal wait-stated RAM (index wraps modulo 2**RAM_AW); the rest
//   go to an external I/O window through an io_req/io_ack handshake with a
//   timeout. Completion is signalled by a one-cycle ready pulse (err with it on
//   I/O timeout).
//   Ports:
//     clk, rst              clock (rising) / asynchronous active-high reset
//     ld_mar, ld_mdr        load MAR / MDR from data_bus (honoured in IDLE only)
//     mio_en, r_w           start access (IDLE only); r_w 1=write, 0=read
//     gate_mdr, mem_out     mem_out = MDR when gate_mdr, else zero
//     data_bus              datapath bus
//     ready, err, busy      completion pulse, timeout flag, not-IDLE
//     io_req, io_we         I/O request / write qualifier
//     io_addr, io_wdata     I/O address / write data of the current access
//     io_rdata, io_ack      I/O read data / acknowledge
// ---------------------------------------------------------------------------
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int            DW          = 16,
  parameter int            AW          = 16,
  parameter int            RAM_AW      = 12,
  parameter logic [AW-1:0] IO_BASE     = 16'hFE00,
  parameter int            WAIT_CYCLES = 2,
  parameter int            IO_TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_mar,
  input  logic          ld_mdr,
  input  logic          mio_en,
  input  logic          r_w,
  input  logic          gate_mdr,
  input  logic [DW-1:0] data_bus,
  output logic [DW-1:0] mem_out,
  output logic          ready,
  output logic          err,
  output logic          busy,
  output logic          io_req,
  output logic          io_we,
  output logic [AW-1:0] io_addr,
  output logic [DW-1:0] io_wdata,
  input  logic [DW-1:0] io_rdata,
  input  logic          io_ack
);

  localparam int CW = 4;
  localparam int TW = $clog2(IO_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] mdr_q, mdr_d;
  // Snapshot of MAR/MDR/r_w at accept: a same-edge ld_* must not disturb
  // the access that was just started.
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;

  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_rdata;

  lc3_ram_array #(
    .DW     (DW),
    .RAM_AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q[RAM_AW-1:0];

    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (ld_mar) mar_d = data_bus[AW-1:0];
        if (ld_mdr) mdr_d = data_bus;
        if (mio_en) begin
          addr_d  = mar_q;
          wdata_d = mdr_q;
          we_d    = r_w;
          if (mar_q < IO_BASE) begin
            state_d  = ST_RAM_WAIT;
            cnt_d    = CW'(WAIT_CYCLES);
            // Prime the synchronous read so data is ready even with zero waits.
            ram_en   = (r_w == R_W_READ);
            ram_addr = mar_q[RAM_AW-1:0];
          end else begin
            state_d = ST_IO_REQ;
            tcnt_d  = '0;
          end
        end
      end

      ST_RAM_WAIT: begin
        // Keep re-reading during the wait; rdata then always reflects addr_q.
        ram_en = 1'b1;
        if (cnt_q == '0) begin
          ram_we  = (we_q == R_W_WRITE);
          if (we_q == R_W_READ) mdr_d = ram_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_IO_REQ: begin
        if (io_ack) begin
          if (we_q == R_W_READ) mdr_d = io_rdata;
          state_d = ST_DONE;
        end else if (tcnt_q == TW'(IO_TIMEOUT - 1)) begin
          if (we_q == R_W_READ) mdr_d = '1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  assign ready    = (state_q == ST_DONE);
  assign err      = ready & err_q;
  assign busy     = (state_q != ST_IDLE);
  assign io_req   = (state_q == ST_IO_REQ);
  assign io_we    = we_q;
  assign io_addr  = addr_q;
  assign io_wdata = wdata_q;
  assign mem_out  = gate_mdr ? mdr_q : '0;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
module tb_lc3_mem_ctrl;

  localparam int          DW     = 16;
  localparam int          AW     = 16;
  localparam int          RAM_AW = 12;
  localparam logic [15:0] IOB    = 16'hFE00;
  localparam int          WAITC  = 2;
  localparam int          TMO    = 64;

  logic          clk, rst;
  logic          ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
  logic [DW-1:0] data_bus, mem_out, io_wdata, io_rdata;
  logic          ready, err, busy, io_req, io_we, io_ack;
  logic [AW-1:0] io_addr;

  lc3_mem_ctrl #(
    .DW(DW), .AW(AW), .RAM_AW(RAM_AW), .IO_BASE(IOB),
    .WAIT_CYCLES(WAITC), .IO_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en),
    .r_w(r_w), .gate_mdr(gate_mdr), .data_bus(data_bus), .mem_out(mem_out),
    .ready(ready), .err(err), .busy(busy), .io_req(io_req), .io_we(io_we),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: memory contents, MAR and MDR as the architecture sees them.
  logic [15:0] ram_m [4096];
  bit          ram_v [4096];
  logic [15:0] mar_m, mdr_m;

  typedef struct {
    logic        err;
    logic [15:0] mdr;
    int          lat;
    int          t0;
  } exp_t;
  exp_t q[$];
  exp_t me;

  // Monitor: every ready pulse consumes one expected completion.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no completion", cyc);
      end else begin
        me = q.pop_front();
        check("err", {31'd0, err}, {31'd0, me.err});
        check("mdr", {16'd0, mem_out}, {16'd0, me.mdr});
        check("latency", cyc - me.t0, me.lat);
      end
    end
    if (!rst && err && !ready) begin
      vectors++;
      miscompares++;
      $display("FAIL err_without_ready: got err=1 ready=0 expected err only with ready");
    end
  end

  task automatic load_mar(input logic [15:0] v);
    @(negedge clk);
    data_bus = v; ld_mar = 1'b1;
    @(posedge clk); #1 ld_mar = 1'b0;
    mar_m = v;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    @(negedge clk);
    data_bus = v; ld_mdr = 1'b1;
    @(posedge clk); #1 ld_mdr = 1'b0;
    mdr_m = v;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // One access using the model's MAR/MDR. dly >= TMO means the device never acks.
  task automatic access(input logic rw, input int dly, input logic [15:0] rd, input bit lock);
    exp_t e;
    int   idx;
    bit   is_io;
    int   n;
    is_io = (mar_m >= IOB);
    e.err = 1'b0;
    if (!is_io) begin
      idx   = int'(mar_m[RAM_AW-1:0]);
      e.lat = WAITC + 1;
      if (rw) begin
        ram_m[idx] = mdr_m;
        ram_v[idx] = 1'b1;
      end else begin
        mdr_m = ram_m[idx];
      end
    end else if (dly < TMO) begin
      e.lat = dly + 1;
      if (!rw) mdr_m = rd;
    end else begin
      e.lat = TMO;
      e.err = 1'b1;
      if (!rw) mdr_m = 16'hFFFF;
    end
    e.mdr = mdr_m;

    @(negedge clk);
    r_w = rw; mio_en = 1'b1;
    @(posedge clk); #1 mio_en = 1'b0;
    e.t0 = cyc;
    q.push_back(e);

    if (is_io) begin
      check("io_req_up", {31'd0, io_req}, 32'd1);
      check("io_addr", {16'd0, io_addr}, {16'd0, mar_m});
      check("io_we", {31'd0, io_we}, {31'd0, rw});
      if (rw) check("io_wdata", {16'd0, io_wdata}, {16'd0, mdr_m});
      if (dly < TMO) begin
        io_rdata = rd;
        repeat (dly) @(posedge clk);
        #1 io_ack = 1'b1;
        @(posedge clk); #1 io_ack = 1'b0;
        io_rdata = $urandom;
      end else begin
        n = 0;
        for (int i = 0; i < TMO + 20; i++) begin
          @(negedge clk);
          if (io_req) n++;
          else break;
        end
        check("io_req_cycles", n, TMO);
      end
    end else if (lock) begin
      // Hammer the control inputs while the RAM access is in its wait states.
      @(negedge clk);
      data_bus = 16'h7777; ld_mar = 1'b1; ld_mdr = 1'b1; mio_en = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] a, d;
    int op;
    rst = 1'b1; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    gate_mdr = 1'b1; data_bus = '0; io_rdata = '0; io_ack = 1'b0;
    mar_m = '0; mdr_m = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_io_req", {31'd0, io_req}, 32'd0);
    check("rst_mdr", {16'd0, mem_out}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // RAM write then read back, gate_mdr on/off
    load_mar(16'h0010); load_mdr(16'h1234);
    access(1'b1, 0, 16'h0, 1'b0);
    load_mdr(16'h0000);
    access(1'b0, 0, 16'h0, 1'b0);
    @(negedge clk); gate_mdr = 1'b0; #1;
    check("gate_off", {16'd0, mem_out}, 32'd0);
    gate_mdr = 1'b1; #1;
    check("gate_on", {16'd0, mem_out}, 32'h1234);

    // I/O read with ack after 5 cycles
    load_mar(16'hFE02);
    access(1'b0, 5, 16'h00A5, 1'b0);
    // I/O write
    load_mar(16'hFE06); load_mdr(16'h5A5A);
    access(1'b1, 3, 16'h0, 1'b0);
    // I/O timeout read
    load_mar(16'hFE04);
    access(1'b0, TMO, 16'h0, 1'b0);
    // Ack on the timeout edge still succeeds
    load_mar(16'hFE0A);
    access(1'b0, TMO - 1, 16'h3C3C, 1'b0);

    // Index wraps modulo DEPTH
    load_mar(16'h1030); load_mdr(16'hCAFE);
    access(1'b1, 0, 16'h0, 1'b0);
    load_mar(16'h0030);
    access(1'b0, 0, 16'h0, 1'b0);

    // Busy lockout: read with control inputs toggled during the wait states,
    // then a second read without reloading MAR must hit the same address.
    load_mar(16'h0010);
    access(1'b0, 0, 16'h0, 1'b1);
    access(1'b0, 0, 16'h0, 1'b0);

    // Reset mid-write and mid-I/O
    load_mar(16'h0000); load_mdr(16'h0BAD);
    access(1'b1, 0, 16'h0, 1'b0);
    load_mar(16'h0020); load_mdr(16'h1111);
    access(1'b1, 0, 16'h0, 1'b0);
    load_mdr(16'hBEEF);
    @(negedge clk); r_w = 1'b1; mio_en = 1'b1;
    @(posedge clk); #1 mio_en = 1'b0;
    @(negedge clk); #1 rst = 1'b1; #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_mdr", {16'd0, mem_out}, 32'd0);
    #1 rst = 1'b0;
    mar_m = '0; mdr_m = '0;
    load_mar(16'hFE08);
    @(negedge clk); r_w = 1'b0; mio_en = 1'b1;
    @(posedge clk); #1 mio_en = 1'b0;
    check("io_req_before_rst", {31'd0, io_req}, 32'd1);
    #2 rst = 1'b1; #1;
    check("io_req_async_drop", {31'd0, io_req}, 32'd0);
    #1 rst = 1'b0;
    mar_m = '0; mdr_m = '0;
    // MAR reset to 0: read without loading MAR returns RAM[0]
    access(1'b0, 0, 16'h0, 1'b0);
    load_mar(16'h0020);
    access(1'b0, 0, 16'h0, 1'b0);

    // Randomized mix
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 3);
      if (op < 2) begin
        a = 16'(($urandom_range(0, 7) << 4) | ($urandom_range(0, 1) ? 16'h2000 : 16'h0000));
        load_mar(a);
        if (op == 1 || !ram_v[int'(a[RAM_AW-1:0])]) begin
          d = 16'($urandom);
          load_mdr(d);
          access(1'b1, 0, 16'h0, 1'b0);
        end else begin
          access(1'b0, 0, 16'h0, 1'b0);
        end
      end else begin
        a = IOB | 16'($urandom_range(0, 511));
        load_mar(a);
        d = 16'($urandom);
        if (op == 3) load_mdr(d);
        access(op == 3, $urandom_range(0, 12), 16'($urandom), 1'b0);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
